// File: rtl/hippo_lsu_pkg.sv
// Shared types for the hippo load/store stage: memory access width,
// LSU state encoding, data-memory address width, and a width-to-bytes helper.
package hippo_lsu_pkg;

  // Byte-address width of data memory.
  localparam int unsigned DMemAddrWidth = 12;

  // Access width as understood by interleaved_memory; 2'b11 is not a legal width.
  typedef enum logic [1:0] {
    BYTE     = 2'b00,
    HALFWORD = 2'b01,
    WORD     = 2'b10
  } mem_width_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MEM  = 2'b01,
    RESP = 2'b10
  } lsu_state_t;

  // Number of bytes touched by an access; 0 flags an illegal width.
  function automatic logic [2:0] width_bytes(input mem_width_t w);
    case (w)
      BYTE:     width_bytes = 3'd1;
      HALFWORD: width_bytes = 3'd2;
      WORD:     width_bytes = 3'd4;
      default:  width_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/hippo_lsu.sv
// hippo_lsu: load/store request stage in front of interleaved_memory.
// Accepts one request at a time, forwards it to memory, captures the
// next-cycle read data and returns it as a registered response.
// Out-of-range and illegal-width accesses get an error response without
// touching memory. Define HIPPO_LSU_MISALIGN_TRAP_EN to also reject
// misaligned HALFWORD/WORD accesses.
module hippo_lsu
  import hippo_lsu_pkg::*;
#(
  parameter int unsigned AddrWidth    = DMemAddrWidth,
  parameter bit          StoreRspZero = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  mem_width_t           req_width_i,
  input  logic                 req_sign_extend_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [31:0]          req_data_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_data_o,
  output logic                 rsp_err_o,
  output mem_width_t           mem_width_o,
  output logic                 mem_sign_extend_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_data_o,
  output logic                 mem_we_o,
  input  logic [31:0]          mem_data_i
);

  lsu_state_t          state_q;
  logic                rsp_valid_q;
  logic [31:0]         rsp_data_q;
  logic                rsp_err_q;
  logic                store_q;

  logic [2:0]          nbytes;
  logic [AddrWidth:0]  last_addr;
  logic                width_bad;
  logic                range_bad;
  logic                misalign;
  logic                err;
  logic                accept;

  // Request check: illegal width, or last touched byte beyond the address space
  // (computed one bit wider so the sum cannot wrap).
  always_comb begin
    nbytes    = width_bytes(req_width_i);
    width_bad = (nbytes == 3'd0);
    last_addr = {1'b0, req_addr_i} + {{(AddrWidth-2){1'b0}}, nbytes}
              - {{AddrWidth{1'b0}}, 1'b1};
    range_bad = last_addr[AddrWidth];
`ifdef HIPPO_LSU_MISALIGN_TRAP_EN
    misalign  = ((req_width_i == HALFWORD) && req_addr_i[0]) ||
                ((req_width_i == WORD) && (req_addr_i[1:0] != 2'b00));
`else
    misalign  = 1'b0;
`endif
    err       = width_bad | range_bad | misalign;
  end

  // Request ready depends on state; in RESP a new request rides on the response handshake.
  always_comb begin
    case (state_q)
      IDLE:    req_ready_o = 1'b1;
      RESP:    req_ready_o = rsp_ready_i;
      default: req_ready_o = 1'b0;
    endcase
  end

  assign accept            = req_valid_i & req_ready_o;
  assign mem_width_o       = req_width_i;
  assign mem_sign_extend_o = req_sign_extend_i;
  assign mem_addr_o        = req_addr_i;
  assign mem_data_o        = req_data_i;
  assign mem_we_o          = accept & req_we_i & ~err;

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

  // Control FSM with registered response outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      store_q     <= 1'b0;
    end else begin
      case (state_q)
        // IDLE and RESP share the accept path; accept already folds in rsp_ready_i for RESP.
        IDLE, RESP: begin
          if (accept) begin
            if (err) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q     <= MEM;
              rsp_valid_q <= 1'b0;
              store_q     <= req_we_i;
            end
          end else if ((state_q == RESP) && rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        MEM: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= (store_q && StoreRspZero) ? '0 : mem_data_i;
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hippo_lsu.sv
// Scoreboard bench for hippo_lsu: a byte-array reference model predicts each
// response at accept time; a monitor pops and compares whenever a response
// is presented. A simple registered byte memory stands in for interleaved_memory.
module tb_hippo_lsu;
  import hippo_lsu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  mem_width_t  req_width_i;
  logic        req_sign_extend_i;
  logic [11:0] req_addr_i;
  logic [31:0] req_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  mem_width_t  mem_width_o;
  logic        mem_sign_extend_o;
  logic [11:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_we_o;
  logic [31:0] mem_data_i = '0;

  hippo_lsu #(.AddrWidth(12), .StoreRspZero(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_width_i(req_width_i), .req_sign_extend_i(req_sign_extend_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .mem_width_o(mem_width_o), .mem_sign_extend_o(mem_sign_extend_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_we_o(mem_we_o),
    .mem_data_i(mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Stand-in memory: reads the addressed bytes (old contents) every edge, writes on mem_we_o.
  logic [7:0] emem [4096] = '{default: 8'h00};
  always @(posedge clk_i) begin
    logic [31:0] v;
    int n;
    n = (mem_width_o == BYTE) ? 1 : (mem_width_o == HALFWORD) ? 2 : 4;
    v = '0;
    for (int i = 0; i < n; i++)
      v = v | (32'(emem[(int'(mem_addr_o) + i) % 4096]) << (8 * i));
    if (mem_sign_extend_o && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (mem_sign_extend_o && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    mem_data_i <= v;
    if (mem_we_o)
      for (int i = 0; i < n; i++)
        emem[(int'(mem_addr_o) + i) % 4096] <= mem_data_o[8*i +: 8];
  end

  // Reference model
  logic [7:0] ref_mem [4096] = '{default: 8'h00};

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          first;
  } exp_t;
  exp_t exp_q[$];

  function automatic int nbytes_of(input mem_width_t w);
    if (w == BYTE) return 1;
    if (w == HALFWORD) return 2;
    if (w == WORD) return 4;
    return 0;
  endfunction

  function automatic logic model_err(input logic [11:0] a, input mem_width_t w);
    int n;
    n = nbytes_of(w);
    if (n == 0) return 1'b1;
    if (int'(a) + n > 4096) return 1'b1;
`ifdef HIPPO_LSU_MISALIGN_TRAP_EN
    if (int'(a) % n != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [11:0] a, input mem_width_t w,
                                             input logic sx);
    longint v;
    int n;
    n = nbytes_of(w);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[int'(a) + i]) << (8 * i));
    if (sx && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  bit rnd_ready = 1'b0;

  task automatic set_ready();
    if (rnd_ready) rsp_ready_i = ($urandom_range(0, 3) != 0);
    else           rsp_ready_i = 1'b1;
  endtask

  // Drive one request (called at a negedge) until accepted; predict its response.
  task automatic do_req(input logic we, input mem_width_t w, input logic sx,
                        input logic [11:0] a, input logic [31:0] d);
    bit   done;
    logic e_err;
    exp_t e;
    done = 1'b0;
    req_valid_i = 1'b1;
    req_we_i = we;
    req_width_i = w;
    req_sign_extend_i = sx;
    req_addr_i = a;
    req_data_i = d;
    for (int t = 0; t < 200 && !done; t++) begin
      set_ready();
      #1;
      e_err = model_err(a, w);
      chk("mem_addr", 32'(mem_addr_o), 32'(a));
      chk1("mem_we", mem_we_o, req_ready_o & we & ~e_err);
      if (req_ready_o) begin
        e.err   = e_err;
        e.data  = (e_err || we) ? 32'h0 : model_load(a, w, sx);
        e.first = cyc + (e_err ? 1 : 2);
        exp_q.push_back(e);
        if (we && !e_err)
          for (int i = 0; i < nbytes_of(w); i++) ref_mem[int'(a) + i] = 8'((d >> (8 * i)) & 32'hFF);
        @(posedge clk_i);
        done = 1'b1;
      end
      @(negedge clk_i);
    end
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout: request at %h never accepted", a);
    end
    req_valid_i = 1'b0;
  endtask

  // Monitor: compare each presented response with the scoreboard head.
  bit first_seen = 1'b0;
  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_ni !== 1'b1) continue;
      if (rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          chk1("spurious_rsp", rsp_valid_o, 1'b0);
        end else begin
          if (!first_seen) begin
            chk("rsp_latency", 32'(cyc), 32'(exp_q[0].first));
            first_seen = 1'b1;
          end
          chk("rsp_data", rsp_data_o, exp_q[0].data);
          chk1("rsp_err", rsp_err_o, exp_q[0].err);
          if (rsp_ready_i) begin
            void'(exp_q.pop_front());
            first_seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    bit drained;
    rst_ni = 1'b0;
    req_valid_i = 1'b0;
    req_we_i = 1'b0;
    req_width_i = WORD;
    req_sign_extend_i = 1'b0;
    req_addr_i = '0;
    req_data_i = '0;
    rsp_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    chk1("reset_rsp_valid", rsp_valid_o, 1'b0);
    chk("reset_rsp_data", rsp_data_o, 32'h0);
    chk1("reset_rsp_err", rsp_err_o, 1'b0);
    chk1("reset_req_ready", req_ready_o, 1'b1);
    chk1("reset_mem_we", mem_we_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Directed cases
    do_req(1'b1, WORD, 1'b0, 12'h100, 32'hDEAD_BEEF);
    do_req(1'b0, WORD, 1'b0, 12'h100, 32'h0);
    do_req(1'b0, BYTE, 1'b1, 12'h103, 32'h0);
    do_req(1'b0, BYTE, 1'b0, 12'h103, 32'h0);
    do_req(1'b0, WORD, 1'b0, 12'hFFE, 32'h0);
    do_req(1'b1, BYTE, 1'b0, 12'hFFF, 32'h0000_005A);
    do_req(1'b0, BYTE, 1'b1, 12'hFFF, 32'h0);
    do_req(1'b1, HALFWORD, 1'b0, 12'h101, 32'h0000_BEEF);
    do_req(1'b0, HALFWORD, 1'b0, 12'h101, 32'h0);
    do_req(1'b0, WORD, 1'b0, 12'h100, 32'h0);
    do_req(1'b1, mem_width_t'(2'b11), 1'b0, 12'h200, 32'h1234_5678);
    do_req(1'b0, WORD, 1'b0, 12'h200, 32'h0);

    // Response back-pressure with a request waiting
    do_req(1'b0, WORD, 1'b0, 12'h100, 32'h0);
    req_valid_i = 1'b1;
    req_we_i = 1'b0;
    req_width_i = WORD;
    req_addr_i = 12'h104;
    for (int i = 0; i < 6; i++) begin
      rsp_ready_i = 1'b0;
      #1;
      chk1("hold_req_ready", req_ready_o, 1'b0);
      chk1("hold_mem_we", mem_we_o, 1'b0);
      @(negedge clk_i);
    end
    do_req(1'b0, WORD, 1'b0, 12'h104, 32'h0);

    // Reset during MEM discards the in-flight load
    do_req(1'b0, WORD, 1'b0, 12'h100, 32'h0);
    rst_ni = 1'b0;
    #1;
    chk1("midreset_rsp_valid", rsp_valid_o, 1'b0);
    chk1("midreset_req_ready", req_ready_o, 1'b1);
    chk("midreset_rsp_data", rsp_data_o, 32'h0);
    void'(exp_q.pop_back());
    first_seen = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);

    // Randomized traffic around two regions, including the top of memory
    rnd_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      logic [11:0] a;
      mem_width_t  w;
      a = ($urandom_range(0, 1) == 0) ? 12'(32'h0F0 + $urandom_range(0, 31))
                                      : 12'(32'hFF0 + $urandom_range(0, 15));
      w = ($urandom_range(0, 15) == 0) ? mem_width_t'(2'b11)
                                       : mem_width_t'(2'($urandom_range(0, 2)));
      do_req(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        set_ready();
        @(negedge clk_i);
      end
    end

    // Drain outstanding responses
    rnd_ready = 1'b0;
    drained = 1'b0;
    for (int t = 0; t < 50 && !drained; t++) begin
      rsp_ready_i = 1'b1;
      if (exp_q.size() == 0) drained = 1'b1;
      else @(negedge clk_i);
    end
    if (!drained) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
    end
    repeat (3) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
